// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor: one shared digit adder, LSD first,
// valid/ready handshakes on operand and result sides, non-BCD digit flag.
module bcd_serial_addsub #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                sub,
    input  logic                cin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                err
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [CW-1:0] cnt;
    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic          sub_r;
    logic          carry;

    logic [3:0]    a_dig;
    logic [3:0]    b_dig;
    logic [3:0]    b_eff;
    logic [4:0]    t;
    logic [3:0]    digit;
    logic          carry_next;
    logic          dig_bad;
    logic [W+3:0]  sum_ext;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (cnt == LAST) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shared digit adder working on the lowest digit of the shifting operands
    always_comb begin
        a_dig      = a_r[3:0];
        b_dig      = b_r[3:0];
        b_eff      = sub_r ? 4'(4'd9 - b_dig) : b_dig;
        t          = 5'(a_dig) + 5'(b_eff) + 5'(carry);
        digit      = t[3:0];
        carry_next = 1'b0;
        if (t > 5'd9) begin
            digit      = 4'(t + 5'd6);
            carry_next = 1'b1;
        end
        dig_bad    = (a_dig > 4'd9) || (b_dig > 4'd9);
        sum_ext    = {digit, sum};
    end

    // Handshake flags registered from the upcoming state
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
        end
    end

    // Operand capture, digit-serial datapath and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            a_r   <= '0;
            b_r   <= '0;
            sub_r <= 1'b0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b;
                        sub_r <= sub;
                        carry <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_r   <= a_r >> 4;
                    b_r   <= b_r >> 4;
                    carry <= carry_next;
                    // result digits enter at the top and shift down into place
                    sum   <= sum_ext[W+3:4];
                    err   <= ((cnt == '0) ? 1'b0 : err) | dig_bad;
                    if (cnt == LAST) begin
                        cout <= carry_next;
                        cnt  <= '0;
                    end else begin
                        cnt  <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Scoreboard bench for bcd_serial_addsub with DIGITS=4.
module tb_bcd_serial_addsub;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        err;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        err;
        logic        chk_sum;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    bcd_serial_addsub #(.DIGITS(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .err(err)
    );

    always #5 clk = ~clk;

    function automatic int bcd2int(input logic [15:0] v);
        int r = 0;
        for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r;
        int x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic has_bad(input logic [15:0] v);
        logic bad = 1'b0;
        for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push the decimal-arithmetic expectation, hand the op over, wait for the result
    task automatic start_op(input logic [15:0] av, input logic [15:0] bv,
                            input logic sv, input logic cv);
        exp_t e;
        int   v;
        int   cyc;
        e.err     = has_bad(av) | has_bad(bv);
        e.chk_sum = !e.err;
        if (!sv) begin
            v      = bcd2int(av) + bcd2int(bv) + int'(cv);
            e.cout = (v >= 10000);
        end else begin
            v      = 10000 + bcd2int(av) - bcd2int(bv);
            e.cout = (bcd2int(av) >= bcd2int(bv));
        end
        e.sum = int2bcd(v % 10000);
        sb.push_back(e);

        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL start_in_ready: got %b want 1", in_ready);
        end
        in_valid = 1'b1; a = av; b = bv; sub = sv; cin = cv;
        tick();
        // scramble inputs during RUN; they must be ignored
        in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom);
        sub = 1'($urandom); cin = 1'($urandom);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (cyc != 4) begin
            n_fail++;
            $display("FAIL latency: got %0d cycles want 4", cyc);
        end
    endtask

    // Pop the expectation, compare the presented result, complete the handshake
    task automatic collect(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_scoreboard_empty", name);
            return;
        end
        e = sb.pop_front();
        if (e.chk_sum) begin
            n_checks++;
            if (sum !== e.sum) begin
                n_fail++;
                $display("FAIL %s_sum: got %h want %h", name, sum, e.sum);
            end
            n_checks++;
            if (cout !== e.cout) begin
                n_fail++;
                $display("FAIL %s_cout: got %b want %b", name, cout, e.cout);
            end
        end
        n_checks++;
        if (err !== e.err) begin
            n_fail++;
            $display("FAIL %s_err: got %b want %b", name, err, e.err);
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_in_ready_done: got %b want 0", name, in_ready);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_release: got out_valid=%b in_ready=%b want 0/1",
                     name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0; cin = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h0 ||
            cout !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b vld=%b sum=%h cout=%b err=%b want 1 0 0000 0 0",
                     in_ready, out_valid, sum, cout, err);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_add();
        start_op(16'h1234, 16'h5678, 1'b0, 1'b0); collect("add_1234_5678");
        start_op(16'h9999, 16'h0001, 1'b0, 1'b0); collect("add_9999_0001");
        start_op(16'h0999, 16'h0000, 1'b0, 1'b1); collect("add_0999_cin");
    endtask

    task automatic test_sub();
        start_op(16'h0500, 16'h0123, 1'b1, 1'b0); collect("sub_0500_0123");
        start_op(16'h0123, 16'h0500, 1'b1, 1'b1); collect("sub_0123_0500");
        start_op(16'h4321, 16'h4321, 1'b1, 1'b0); collect("sub_equal");
    endtask

    task automatic test_err();
        start_op(16'h12A4, 16'h0000, 1'b0, 1'b0); collect("err_12a4");
        start_op(16'h0001, 16'h0001, 1'b0, 1'b0); collect("err_cleared");
    endtask

    task automatic test_backpressure();
        logic [15:0] s0;
        logic        c0;
        logic        e0;
        start_op(16'h2468, 16'h1357, 1'b0, 1'b1);
        s0 = sum; c0 = cout; e0 = err;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== s0 ||
                cout !== c0 || err !== e0) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got vld=%b rdy=%b sum=%h cout=%b err=%b want 1 0 %h %b %b",
                         i, out_valid, in_ready, sum, cout, err, s0, c0, e0);
            end
        end
        in_valid = 1'b0;
        collect("backpressure");
    endtask

    task automatic test_reset_abort();
        in_valid = 1'b1; a = 16'h7777; b = 16'h2222; sub = 1'b0; cin = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h0) begin
            n_fail++;
            $display("FAIL abort_state: got rdy=%b vld=%b sum=%h want 1 0 0000",
                     in_ready, out_valid, sum);
        end
        repeat (5) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_no_result: got out_valid=%b want 0", out_valid);
            end
        end
        start_op(16'h0001, 16'h0002, 1'b0, 1'b0); collect("after_abort");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            start_op(int2bcd(int'($urandom_range(0, 9999))),
                     int2bcd(int'($urandom_range(0, 9999))),
                     1'($urandom), 1'($urandom));
            collect("b2b");
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_err();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
